mul_pipe_tail: RTL and testbench
================================

# mul_pipe_tail

Back half of the multiply pipeline. It takes each M1 result (register-write flag, destination, 32-bit low product, zero and overflow flags) and carries it through DEPTH further registered stages (M2..M5 by default) to the writeback port. The block also supports stall and flush. It gives the decode stage a combinational hazard check against every multiply still in flight, so dependent instructions can be held.

## Interface
- DEPTH, 4: stages after M1, legal range 2..8; the last stage drives the out_* ports.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  holds every stage; the in_* inputs are not sampled.
- flush  in  1  kills every in-flight entry and the current input.
- in_regwrite  in  1  M1 regwrite_out; 1 marks a valid entry.
- in_dst_reg  in  `REG_ADDR  M1 destination register.
- in_result  in  `REG_SIZE  M1 low-half product.
- in_zero  in  1  M1 zero flag.
- in_overflow  in  1  M1 overflow flag.
- query_ra, query_rb  in  `REG_ADDR  source registers of the instruction in decode.
- hazard_a, hazard_b  out  1  combinational; a pending multiply writes the queried register.
- out_regwrite  out  1  writeback enable from the last stage.
- out_dst_reg  out  `REG_ADDR  writeback register.
- out_result  out  `REG_SIZE  writeback data.
- out_zero, out_overflow  out  1  flags travelling with the result.
- inflight  out  4  number of valid stages, 0..DEPTH.
- busy  out  1  inflight != 0.

## Operation
- Stage i (1..DEPTH) holds these fields: v, dst, res, z, ov.
- Stage 1 loads from in_*, stage i loads from stage i-1, and out_* is stage DEPTH.
- The valid bit v of a new entry is in_regwrite.
- When in_regwrite=0 the entry is a bubble: dst, res, z and ov are loaded as 0, whatever the other in_* values are.
- The pipeline advances only when stall=0 and flush=0.
- stall=1, flush=0: every stage holds its value, including the output stage.
  - The input presented that cycle is dropped.
  - Upstream must not issue while stall is high.
- flush=1: every v clears on the next edge and data fields clear to 0. Flush beats stall, and the input that cycle is discarded.
- Hazard rule:
  - hazard_a = OR over stages of (v_i && dst_i == query_ra).
  - The compare also includes the input term (in_regwrite && in_dst_reg == query_ra), because that entry is the one still in M1.
  - The out stage is included, since writeback has not happened yet.
  - hazard_b uses the same rule against query_rb.
- Register 0 never raises a hazard: query 0 gives 0, and a dst of 0 still travels through but is never matched.
- inflight is a registered count.
  - Next value = current + incoming valid − outgoing valid when advancing, the current value when stalled, and 0 on flush.
  - Incoming valid is in_regwrite. Outgoing valid is v_DEPTH.
  - The count must always equal the population count of the v bits; an assertion checks this.
- Result, zero and overflow are passed through untouched. This block does no arithmetic.

## Timing
- Reset (async assert, synchronous release at the next edge): all v=0 and all data=0. Outputs are out_regwrite=0, out_dst_reg=0, out_result=0, out_zero=0, out_overflow=0, inflight=0, busy=0.
- Reset mid-operation drops all entries immediately.
- The hazard outputs follow the query inputs with no clock, so with every v=0 they are 0 during reset.
- Latency: an entry sampled at edge k (stall=0) appears on out_* after edge k+DEPTH-1, so it is visible for writeback in the cycle before edge k+DEPTH.
- Each stall cycle adds exactly one cycle of latency. Entries are never duplicated or reordered.
- Throughput is one entry per cycle when there is no stall.
- Hazard outputs are purely combinational from stage registers, in_regwrite, in_dst_reg and the queries. There is no path from stall or flush to the hazard outputs.
- Flush asserted at edge k: out_regwrite=0 and inflight=0 after edge k. Hazards drop in the same cycle, apart from the input term.

## Test plan
- Reset then single entry: in_regwrite=1, dst=5, res=32'h12345678, z=0, ov=1 at edge 1, DEPTH=4. Expected: out_regwrite=1, dst=5, res=32'h12345678, ov=1 after edge 4, then out_regwrite=0 after edge 5. inflight goes 1,1,1,1,0.
- Back-to-back stream: dst=1..6 on consecutive cycles. Expected: out_dst_reg reads 1..6 on consecutive cycles, and inflight peaks at 4.
- Stall: with dst=3 at stage 2, hold stall=1 for 3 cycles. Expected: every stage, inflight and out_* are frozen. dst=3 reaches the output 3 cycles later than without the stall, and the input offered during the stall never appears.
- Flush with simultaneous stall: 3 entries in flight, flush=1 and stall=1 together. Expected: after the edge, inflight=0, busy=0, out_regwrite=0, and no stale entry ever emerges.
- Hazards:
  - query_ra=7 with dst 7 in stage 3: hazard_a=1.
  - query_rb=7 with 7 only on the input: hazard_b=1.
  - query_ra=0 with a dst-0 entry in flight: hazard_a=0.
  - When the dst-7 entry leaves the out stage: hazard_a=0.
- Reset mid-stream: assert rst_n=0 asynchronously with 4 entries in flight. Expected: all outputs 0 immediately, and after release the next entry passes through with normal latency.

Source files
------------

// File: rtl/mul_pipe_tail.sv
// Back half of the multiply pipeline: carries M1 results through DEPTH registered
// stages to writeback, with stall/flush and a combinational hazard check for decode.

`ifndef REG_ADDR
`define REG_ADDR 4:0
`endif
`ifndef REG_SIZE
`define REG_SIZE 31:0
`endif

module mul_pipe_tail #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_regwrite,
    input  logic [`REG_ADDR] in_dst_reg,
    input  logic [`REG_SIZE] in_result,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic [`REG_ADDR] query_ra,
    input  logic [`REG_ADDR] query_rb,
    output logic             hazard_a,
    output logic             hazard_b,
    output logic             out_regwrite,
    output logic [`REG_ADDR] out_dst_reg,
    output logic [`REG_SIZE] out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic [3:0]       inflight,
    output logic             busy
);

    // Index 0 is the first stage after M1, index DEPTH-1 drives the out_* ports.
    logic [DEPTH-1:0] v_q, v_d;
    logic [`REG_ADDR] dst_q [DEPTH];
    logic [`REG_ADDR] dst_d [DEPTH];
    logic [`REG_SIZE] res_q [DEPTH];
    logic [`REG_SIZE] res_d [DEPTH];
    logic [DEPTH-1:0] z_q, z_d;
    logic [DEPTH-1:0] ov_q, ov_d;
    logic [3:0]       inflight_q, inflight_d;

    logic             advance;
    logic [`REG_ADDR] head_dst;
    logic [`REG_SIZE] head_res;
    logic             head_z;
    logic             head_ov;

    assign advance = !stall && !flush;

    // Bubbles enter with all data fields zeroed so nothing stale rides behind v=0.
    assign head_dst = in_regwrite ? in_dst_reg  : '0;
    assign head_res = in_regwrite ? in_result   : '0;
    assign head_z   = in_regwrite & in_zero;
    assign head_ov  = in_regwrite & in_overflow;

    always_comb begin
        v_d  = v_q;
        z_d  = z_q;
        ov_d = ov_q;
        for (int i = 0; i < DEPTH; i++) begin
            dst_d[i] = dst_q[i];
            res_d[i] = res_q[i];
        end
        if (flush) begin
            v_d  = '0;
            z_d  = '0;
            ov_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                dst_d[i] = '0;
                res_d[i] = '0;
            end
        end else if (advance) begin
            v_d  = {v_q[DEPTH-2:0],  in_regwrite};
            z_d  = {z_q[DEPTH-2:0],  head_z};
            ov_d = {ov_q[DEPTH-2:0], head_ov};
            dst_d[0] = head_dst;
            res_d[0] = head_res;
            for (int i = 1; i < DEPTH; i++) begin
                dst_d[i] = dst_q[i-1];
                res_d[i] = res_q[i-1];
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (advance) begin
            inflight_d = inflight_q + {3'b000, in_regwrite} - {3'b000, v_q[DEPTH-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            z_q        <= '0;
            ov_q       <= '0;
            inflight_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            v_q        <= v_d;
            z_q        <= z_d;
            ov_q       <= ov_d;
            inflight_q <= inflight_d;
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i] <= dst_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    // Per-stage match vectors; the out stage is included because writeback is still pending.
    logic [DEPTH-1:0] match_a;
    logic [DEPTH-1:0] match_b;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_a[gi] = v_q[gi] && (dst_q[gi] == query_ra);
            assign match_b[gi] = v_q[gi] && (dst_q[gi] == query_rb);
        end
    endgenerate

    logic in_hit_a;
    logic in_hit_b;

    assign in_hit_a = in_regwrite && (in_dst_reg == query_ra);
    assign in_hit_b = in_regwrite && (in_dst_reg == query_rb);

    // r0 is hardwired, so a query of 0 can never depend on an in-flight write.
    assign hazard_a = (query_ra != '0) && ((|match_a) || in_hit_a);
    assign hazard_b = (query_rb != '0) && ((|match_b) || in_hit_b);

    assign out_regwrite = v_q[DEPTH-1];
    assign out_dst_reg  = dst_q[DEPTH-1];
    assign out_result   = res_q[DEPTH-1];
    assign out_zero     = z_q[DEPTH-1];
    assign out_overflow = ov_q[DEPTH-1];
    assign inflight     = inflight_q;
    assign busy         = (inflight_q != '0);

`ifndef SYNTHESIS
    a_inflight_matches_valids : assert property (
        @(posedge clk) disable iff (!rst_n)
        int'(inflight_q) == $countones(v_q)
    );
`endif

endmodule

// File: tb/tb_mul_pipe_tail.sv
// Randomized and directed bench for mul_pipe_tail, checked against a queue-based
// model where each accepted entry ages by one per advancing cycle.

module tb_mul_pipe_tail;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_regwrite;
    logic [4:0]  in_dst_reg;
    logic [31:0] in_result;
    logic        in_zero;
    logic        in_overflow;
    logic [4:0]  query_ra;
    logic [4:0]  query_rb;
    logic        hazard_a;
    logic        hazard_b;
    logic        out_regwrite;
    logic [4:0]  out_dst_reg;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic [3:0]  inflight;
    logic        busy;

    mul_pipe_tail #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .in_regwrite  (in_regwrite),
        .in_dst_reg   (in_dst_reg),
        .in_result    (in_result),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .query_ra     (query_ra),
        .query_rb     (query_rb),
        .hazard_a     (hazard_a),
        .hazard_b     (hazard_b),
        .out_regwrite (out_regwrite),
        .out_dst_reg  (out_dst_reg),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .inflight     (inflight),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] res;
        logic        z;
        logic        ov;
        int          age;
    } ent_t;

    ent_t model_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_hazard(input logic [4:0] q);
        logic h;
        h = in_regwrite && (in_dst_reg == q);
        foreach (model_q[i]) if (model_q[i].dst == q) h = 1'b1;
        return (q != 5'd0) && h;
    endfunction

    task automatic check_all(input string tag);
        logic        e_rw;
        logic [4:0]  e_dst;
        logic [31:0] e_res;
        logic        e_z;
        logic        e_ov;
        e_rw = 1'b0; e_dst = '0; e_res = '0; e_z = 1'b0; e_ov = 1'b0;
        if (model_q.size() > 0 && model_q[0].age == DEPTH - 1) begin
            e_rw  = 1'b1;
            e_dst = model_q[0].dst;
            e_res = model_q[0].res;
            e_z   = model_q[0].z;
            e_ov  = model_q[0].ov;
        end
        chk({tag, ".rw"},   32'(out_regwrite), 32'(e_rw));
        chk({tag, ".dst"},  32'(out_dst_reg),  32'(e_dst));
        chk({tag, ".res"},  out_result,        e_res);
        chk({tag, ".z"},    32'(out_zero),     32'(e_z));
        chk({tag, ".ov"},   32'(out_overflow), 32'(e_ov));
        chk({tag, ".infl"}, 32'(inflight),     32'(model_q.size()));
        chk({tag, ".busy"}, 32'(busy),         32'(model_q.size() != 0));
        chk({tag, ".hza"},  32'(hazard_a),     32'(model_hazard(query_ra)));
        chk({tag, ".hzb"},  32'(hazard_b),     32'(model_hazard(query_rb)));
        $display("txn %-8s rw=%0b dst=%0d res=%08h infl=%0d hz=%0b%0b", tag,
                 out_regwrite, out_dst_reg, out_result, inflight, hazard_a, hazard_b);
    endtask

    // Apply the effect of one rising edge using the inputs currently driven.
    task automatic model_edge();
        ent_t e;
        if (flush) begin
            model_q.delete();
        end else if (!stall) begin
            foreach (model_q[i]) model_q[i].age = model_q[i].age + 1;
            while (model_q.size() > 0 && model_q[0].age >= DEPTH) void'(model_q.pop_front());
            if (in_regwrite) begin
                e.dst = in_dst_reg; e.res = in_result; e.z = in_zero; e.ov = in_overflow; e.age = 0;
                model_q.push_back(e);
            end
        end
    endtask

    // Called 1ns after a rising edge; returns 1ns after the next one.
    task automatic step(input logic rw, input logic [4:0] dst, input logic [31:0] res,
                        input logic z, input logic ov, input logic st, input logic fl,
                        input logic [4:0] qa, input logic [4:0] qb, input string tag);
        in_regwrite = rw; in_dst_reg = dst; in_result = res; in_zero = z; in_overflow = ov;
        stall = st; flush = fl; query_ra = qa; query_rb = qb;
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] qa, input logic [4:0] qb, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, qa, qb, tag);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        in_regwrite = 1'b0; in_dst_reg = '0; in_result = '0; in_zero = 1'b0; in_overflow = 1'b0;
        query_ra = 5'd7; query_rb = 5'd3;

        @(posedge clk);
        #1;
        check_all("reset");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(1'b1, 5'd5, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, "single");
        idle(6, 5'd5, 5'd0, "single");

        for (int d = 1; d <= 6; d++)
            step(1'b1, 5'(d), $urandom, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 5'(d), 5'd1, "stream");
        idle(6, 5'd6, 5'd1, "stream");

        step(1'b1, 5'd3, 32'hCAFE0003, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd9, "stall");
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd9, "stall");
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd9, 32'hDEAD0009, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd9, "stall");
        idle(6, 5'd3, 5'd9, "stall");

        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(10 + i), $urandom, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 5'd12, "flush");
        step(1'b1, 5'd11, 32'hBAD0000B, 1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 5'd11, "flush");
        idle(6, 5'd10, 5'd11, "flush");

        step(1'b1, 5'd7, 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, "hazard");
        step(1'b1, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, "hazard");
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0, "hazard");
        idle(6, 5'd7, 5'd0, "hazard");

        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(20 + i), $urandom, 1'b1, 1'b1, 1'b0, 1'b0, 5'd20, 5'd23, "midrst");
        in_regwrite = 1'b0; in_dst_reg = '0;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        check_all("midrst");
        #2 rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        step(1'b1, 5'd21, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 1'b0, 5'd21, 5'd20, "postrst");
        idle(6, 5'd21, 5'd20, "postrst");

        for (int n = 0; n < 500; n++)
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), "random");
        idle(DEPTH + 2, 5'd1, 5'd2, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
